// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC unit: holds the fetch PC, picks the next PC from the hazard
// unit's select, and buffers a redirect that lands while PC writes are stalled.
module fetch_pc_unit #(
    parameter logic [31:0] PC_INIT    = 32'h0000_0000,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PC_WEN,
    input  logic [1:0]  PCSrc_check,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    input  logic        halt,
    input  logic        ihit,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic        redirect_pending,
    output logic        halted
);

    typedef enum logic {RUN, HALT} state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic        pend_q, pend_d;
    logic [31:0] raw_target;
    logic [31:0] redirect_target;

    // ihit is already folded into PC_WEN upstream; kept on the port for visibility.
    logic unused_ihit;
    assign unused_ihit = ihit;

    assign pc               = pc_q;
    assign iaddr            = pc_q;
    assign pc_plus4         = pc_q + 32'(WORD_BYTES);
    assign iREN             = (state_q == RUN);
    assign halted           = (state_q == HALT);
    assign redirect_pending = pend_q;

    always_comb begin
        raw_target = jr_target;
        case (PCSrc_check)
            SEL_BR:  raw_target = br_target;
            SEL_J:   raw_target = j_target;
            default: raw_target = jr_target;
        endcase
        redirect_target = {raw_target[31:2], 2'b00};
    end

    // PC_WEN is the only advance qualifier: a cycle with PC_WEN=1 consumes the
    // select; with PC_WEN=0 a non-sequential select is parked in the buffer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                    buf_d   = 32'h0;
                    pend_d  = 1'b0;
                end else if (PC_WEN) begin
                    if (PCSrc_check != SEL_SEQ) begin
                        pc_d = redirect_target;
                    end else if (pend_q) begin
                        pc_d = buf_q;
                    end else begin
                        pc_d = pc_plus4;
                    end
                    buf_d  = 32'h0;
                    pend_d = 1'b0;
                end else if (PCSrc_check != SEL_SEQ) begin
                    buf_d  = redirect_target;
                    pend_d = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            buf_q   <= 32'h0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a spec-level model compared every negedge,
// plus literal expectations on the test-plan scenarios.
module tb_fetch_pc_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_wen = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] br = 32'h0, jt = 32'h0, jr = 32'h0;
    logic        halt = 1'b0;
    logic        ihit = 1'b1;
    logic [31:0] pc, pc_plus4, iaddr;
    logic        iren, pending, halted;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: what the spec says the unit holds
    logic [31:0] m_pc = PC_INIT;
    logic [31:0] m_buf = 32'h0;
    logic        m_pend = 1'b0;
    logic        m_halt = 1'b0;

    fetch_pc_unit #(.PC_INIT(PC_INIT), .WORD_BYTES(4)) dut (
        .CLK(clk), .RST(rst), .PC_WEN(pc_wen), .PCSrc_check(sel),
        .br_target(br), .j_target(jt), .jr_target(jr), .halt(halt), .ihit(ihit),
        .pc(pc), .pc_plus4(pc_plus4), .iREN(iren), .iaddr(iaddr),
        .redirect_pending(pending), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // behavioural model
    always @(posedge clk or posedge rst) begin
        logic [31:0] tgt;
        if (rst) begin
            m_pc = PC_INIT; m_buf = 0; m_pend = 0; m_halt = 0;
        end else if (!m_halt) begin
            tgt = (sel == 2'd1) ? br : (sel == 2'd2) ? jt : jr;
            tgt = tgt & 32'hFFFF_FFFC;
            if (halt) begin
                m_halt = 1; m_pend = 0;
            end else if (pc_wen) begin
                if (sel != 0)   m_pc = tgt;
                else if (m_pend) m_pc = m_buf;
                else            m_pc = m_pc + 32'd4;
                m_pend = 0;
            end else if (sel != 0) begin
                m_buf = tgt; m_pend = 1;
            end
        end
    end

    always @(negedge clk) begin
        cmp("m_pc", pc, m_pc);
        cmp("m_iaddr", iaddr, m_pc);
        cmp("m_pc_plus4", pc_plus4, m_pc + 32'd4);
        cmp("m_iren", {31'h0, iren}, {31'h0, !m_halt});
        cmp("m_pending", {31'h0, pending}, {31'h0, m_pend});
        cmp("m_halted", {31'h0, halted}, {31'h0, m_halt});
    end

    task automatic step(input logic w, input logic [1:0] s, input logic [31:0] b,
                        input logic [31:0] j, input logic [31:0] r, input logic h);
        pc_wen = w; sel = s; br = b; jt = j; jr = r; halt = h;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] exp_pc, input logic exp_pend);
        cmp({name, "_pc"}, pc, exp_pc);
        cmp({name, "_pend"}, {31'h0, pending}, {31'h0, exp_pend});
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp("rst_pc", pc, 32'h0);
        cmp("rst_plus4", pc_plus4, 32'h4);
        cmp("rst_iren", {31'h0, iren}, 32'h1);
        cmp("rst_halted", {31'h0, halted}, 32'h0);
        cmp("rst_pend", {31'h0, pending}, 32'h0);

        // sequential fetch
        step(1, 2'b00, 0, 0, 0, 0); chk("seq1", 32'h4, 0);
        step(1, 2'b00, 0, 0, 0, 0); chk("seq2", 32'h8, 0);
        step(1, 2'b00, 0, 0, 0, 0); chk("seq3", 32'hC, 0);
        cmp("seq_iren", {31'h0, iren}, 32'h1);

        // redirect with write enabled
        step(1, 2'b10, 0, 32'h10, 0, 0); chk("set10", 32'h10, 0);
        step(1, 2'b01, 32'h40, 0, 0, 0); chk("br40", 32'h40, 0);

        // redirect during stall
        step(1, 2'b10, 0, 32'h20, 0, 0);  chk("set20", 32'h20, 0);
        step(0, 2'b10, 0, 32'h100, 0, 0); chk("stall_cap", 32'h20, 1);
        step(0, 2'b00, 0, 0, 0, 0);       chk("stall_hold1", 32'h20, 1);
        step(0, 2'b00, 0, 0, 0, 0);       chk("stall_hold2", 32'h20, 1);
        step(1, 2'b00, 0, 0, 0, 0);       chk("stall_rel", 32'h100, 0);
        step(1, 2'b00, 0, 0, 0, 0);       chk("after_rel", 32'h104, 0);

        // overwrite: later capture replaces earlier
        step(0, 2'b11, 0, 0, 32'h200, 0); chk("ow_cap1", 32'h104, 1);
        step(0, 2'b01, 32'h300, 0, 0, 0); chk("ow_cap2", 32'h104, 1);
        step(1, 2'b00, 0, 0, 0, 0);       chk("ow_rel", 32'h300, 0);

        // newest redirect wins over buffered one
        step(0, 2'b11, 0, 0, 32'h200, 0); chk("nw_cap1", 32'h300, 1);
        step(0, 2'b01, 32'h300, 0, 0, 0); chk("nw_cap2", 32'h300, 1);
        step(1, 2'b10, 0, 32'h400, 0, 0); chk("nw_win", 32'h400, 0);

        // alignment and wrap
        step(1, 2'b11, 0, 0, 32'h1237, 0); chk("align_jr", 32'h1234, 0);
        step(0, 2'b01, 32'h503, 0, 0, 0);  chk("align_cap", 32'h1234, 1);
        step(1, 2'b00, 0, 0, 0, 0);        chk("align_buf", 32'h500, 0);
        step(1, 2'b10, 0, 32'hFFFF_FFFC, 0, 0); chk("wrap_set", 32'hFFFF_FFFC, 0);
        cmp("wrap_plus4", pc_plus4, 32'h0);
        step(1, 2'b00, 0, 0, 0, 0);        chk("wrap_step", 32'h0, 0);

        // halt priority; pending redirect dropped
        step(1, 2'b10, 0, 32'h50, 0, 0);   chk("set50", 32'h50, 0);
        step(0, 2'b01, 32'h80, 0, 0, 0);   chk("pre_halt_cap", 32'h50, 1);
        step(1, 2'b01, 32'h90, 0, 0, 1);   chk("halt", 32'h50, 0);
        cmp("halt_halted", {31'h0, halted}, 32'h1);
        cmp("halt_iren", {31'h0, iren}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom, 1'($urandom_range(0, 1)));
            cmp("halt_hold_pc", pc, 32'h50);
            cmp("halt_hold_halted", {31'h0, halted}, 32'h1);
            cmp("halt_hold_iren", {31'h0, iren}, 32'h0);
        end

        // asynchronous reset out of HALT, checked before any clock edge
        pc_wen = 0; sel = 0; halt = 0;
        #2 rst = 1'b1;
        #1;
        cmp("arst_pc", pc, PC_INIT);
        cmp("arst_halted", {31'h0, halted}, 32'h0);
        cmp("arst_iren", {31'h0, iren}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 2'b00, 0, 0, 0, 0); chk("post_rst", 32'h4, 0);

        // reset drops a pending redirect
        step(0, 2'b10, 0, 32'h700, 0, 0); chk("pend_700", 32'h4, 1);
        pc_wen = 0; sel = 0;
        #2 rst = 1'b1;
        #1 cmp("arst_pend", {31'h0, pending}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(1, 2'b00, 0, 0, 0, 0); chk("no_stale", 32'h4, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage program-counter unit, directly downstream of the hazard unit.
- Consumes the hazard unit's PC_WEN and PCSrc_check and holds the architectural fetch PC.
- Selects the next PC from sequential, branch, jump or jump-register targets.
- Drives the instruction-memory request.
- Buffers a redirect that resolves while PC writes are stalled, so a taken branch or jump is never lost during an icache miss.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.
- WORD_BYTES, 4, PC increment per sequential fetch.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- PC_WEN  input  1  PC write enable from hazard unit.
- PCSrc_check  input  2  next-PC select from hazard unit: 00 seq, 01 branch, 10 jump, 11 jr.
- br_target  input  32  branch target, computed in execute.
- j_target  input  32  jump target, computed in decode.
- jr_target  input  32  register jump target, forwarded rs value.
- halt  input  1  halt instruction reached commit.
- ihit  input  1  instruction memory returned data this cycle.
- pc  output  32  current fetch PC.
- pc_plus4  output  32  pc + WORD_BYTES.
- iREN  output  1  instruction read request.
- iaddr  output  32  instruction address.
- redirect_pending  output  1  a buffered redirect is waiting.
- halted  output  1  fetch permanently stopped.

Behaviour:
- Reset, asynchronous on RST high:
  - pc = PC_INIT.
  - Redirect buffer cleared, so redirect_pending = 0.
  - halted = 0.
  - The outputs therefore read iREN = 1, iaddr = PC_INIT, pc_plus4 = PC_INIT + 4.
  - Reset asserted mid-operation discards any pending redirect and any halt.
- Combinational outputs:
  - pc_plus4 = pc + WORD_BYTES, modulo 2^32. 32'hFFFFFFFC wraps to 32'h00000000.
  - iaddr = pc.
  - iREN = !halted.
- Target selection, with sel = PCSrc_check:
  - 00 gives pc_plus4, 01 gives br_target, 10 gives j_target, 11 gives jr_target.
  - Every selected non-sequential target has bits [1:0] forced to 00.
- Two states, RUN and HALT; the halted output is 1 exactly in HALT.
- RUN, each rising edge, rules in priority order:
  1. halt = 1: enter HALT. pc is not updated and the buffer is cleared, even if PC_WEN = 1.
  2. PC_WEN = 1 and sel != 00: pc = selected target. The buffer is cleared; the newest redirect wins over a buffered one.
  3. PC_WEN = 1, sel = 00, redirect_pending = 1: pc = buffered target, then clear the buffer.
  4. PC_WEN = 1, sel = 00, no pending redirect: pc = pc_plus4.
  5. PC_WEN = 0 and sel != 00: pc held; capture the aligned target into the buffer and set redirect_pending. A later capture while still pending overwrites the earlier one.
  6. PC_WEN = 0, sel = 00: pc and buffer held.
- HALT:
  - Absorbing; only RST leaves it.
  - pc frozen; all inputs ignored.
  - iREN = 0.
- ihit is informational only; PC advance is governed solely by PC_WEN. The hazard unit already folds ihit into PC_WEN.
- Latency:
  - A redirect presented with PC_WEN = 1 appears on pc one cycle later.
  - A buffered redirect appears one cycle after the first PC_WEN = 1 cycle.
- No X propagation: the buffer target register is reset to 0.

Test Plan:
- Reset and sequential fetch: RST pulse, then PC_WEN = 1, sel = 00 for 3 cycles -> pc reads 0, 4, 8, 0xC; iREN = 1 throughout.
- Redirect with write enabled: pc = 0x10, PC_WEN = 1, sel = 01, br_target = 0x40 -> pc = 0x40 next cycle; redirect_pending stays 0.
- Redirect during stall:
  - Setup: pc = 0x20, PC_WEN = 0, sel = 10, j_target = 0x100 for one cycle, then sel = 00 with PC_WEN = 0 for 2 cycles, then PC_WEN = 1.
  - Required: pc holds 0x20 and redirect_pending = 1 during the stall; pc = 0x100 one cycle after PC_WEN rises; redirect_pending then clears.
- Overwrite and newest-wins:
  - Buffer 0x200 via a stalled jr.
  - Next stalled cycle presents br_target 0x300 -> buffer now holds 0x300.
  - Then PC_WEN = 1 with sel = 10, j_target = 0x400 -> pc = 0x400; pending cleared.
- Alignment and wrap:
  - jr_target = 0x1237 with PC_WEN = 1, sel = 11 -> pc = 0x1234.
  - pc = 0xFFFFFFFC, sequential step -> pc = 0x00000000.
- Halt priority and reset recovery:
  - halt = 1 with PC_WEN = 1, sel = 01 at pc = 0x50 -> pc stays 0x50; halted = 1 and iREN = 0 next cycle, and both persist for 5 further cycles of arbitrary inputs.
  - RST mid-halt -> pc = PC_INIT, halted = 0 immediately, without waiting for a clock edge.
